// File: rtl/comp_tracker_gen_if.sv
// Sample, window-status and correlation-read signals of comp_tracker_gen.
// master drives samples and read requests; slave is the tracker itself.
interface comp_tracker_gen_if #(
    parameter int N_ANTS              = 32,
    parameter int N_POLS              = 2,
    parameter int P_FACTOR_BITS       = 2,
    parameter int BITWIDTH            = 4,
    parameter int SERIAL_ACC_LEN_BITS = 7
) ();
    localparam int DIN_W  = N_POLS * (1 << P_FACTOR_BITS) * BITWIDTH;
    localparam int ANT_W  = $clog2(N_ANTS);
    localparam int CORR_W = P_FACTOR_BITS + BITWIDTH + 2 + SERIAL_ACC_LEN_BITS + 1;

    logic                          sync;
    logic                          din_vld;
    logic [DIN_W-1:0]              din_uint;
    logic [DIN_W-1:0]              din_im;
    logic                          rd_req;
    logic [ANT_W-1:0]              rd_ant_a;
    logic [ANT_W-1:0]              rd_ant_b;
    logic                          rd_ack;
    logic [N_POLS*N_POLS*CORR_W-1:0] re_corr;
    logic [N_POLS*N_POLS*CORR_W-1:0] im_corr;
    logic                          rd_err;
    logic                          rd_buf;
    logic                          win_done;
    logic                          buf_sel;

    modport master (
        output sync, din_vld, din_uint, din_im, rd_req, rd_ant_a, rd_ant_b,
        input  rd_ack, re_corr, im_corr, rd_err, rd_buf, win_done, buf_sel
    );

    modport slave (
        input  sync, din_vld, din_uint, din_im, rd_req, rd_ant_a, rd_ant_b,
        output rd_ack, re_corr, im_corr, rd_err, rd_buf, win_done, buf_sel
    );
endinterface

// File: rtl/comp_tracker_gen.sv
// Per-antenna sum/difference accumulator for time-multiplexed antenna frames,
// double buffered, with a fixed 3-cycle pipelined baseline correlation read.
//
// state | meaning
// IDLE  | after reset; input discarded until a valid sync
// ACC   | accumulating a window into the buffer opposite buf_sel
module comp_tracker_gen #(
    parameter int N_ANTS              = 32,
    parameter int N_POLS              = 2,
    parameter int P_FACTOR_BITS       = 2,
    parameter int BITWIDTH            = 4,
    parameter int SERIAL_ACC_LEN_BITS = 7
) (
    input logic               clk,
    input logic               rst_n,
    comp_tracker_gen_if.slave bus
);
    localparam int P        = 1 << P_FACTOR_BITS;
    localparam int ANT_W    = $clog2(N_ANTS);
    localparam int CNT_W    = ANT_W + SERIAL_ACC_LEN_BITS;
    localparam int ACC_IN_W = P_FACTOR_BITS + BITWIDTH + 2;
    localparam int ACC_W    = ACC_IN_W + SERIAL_ACC_LEN_BITS;
    localparam int CORR_W   = ACC_W + 1;
    localparam int NPP      = N_POLS * N_POLS;

    typedef enum logic {ST_IDLE, ST_ACC} state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic                      w_restart;
    logic                      w_wr_en;
    logic                      w_complete;
    logic                      w_first;
    logic [ANT_W-1:0]          w_wr_ant;
    logic                      w_wr_buf;
    logic [CNT_W-1:0]          r_cnt;
    logic                      r_buf_sel;
    logic                      r_first_done;
    logic                      r_win_done;

    logic signed [ACC_IN_W-1:0] w_re_sum [N_POLS];
    logic signed [ACC_IN_W-1:0] w_im_sum [N_POLS];
    logic signed [ACC_IN_W-1:0] w_s      [N_POLS];
    logic signed [ACC_IN_W-1:0] w_d      [N_POLS];

    logic signed [ACC_W-1:0]    r_acc_s  [2][N_ANTS][N_POLS];
    logic signed [ACC_W-1:0]    r_acc_d  [2][N_ANTS][N_POLS];

    logic                       r1_vld, r1_err, r1_buf;
    logic signed [ACC_W-1:0]    r1_sa [N_POLS];
    logic signed [ACC_W-1:0]    r1_da [N_POLS];
    logic signed [ACC_W-1:0]    r1_sb [N_POLS];
    logic signed [ACC_W-1:0]    r1_db [N_POLS];
    logic                       r2_vld, r2_err, r2_buf;
    logic signed [CORR_W-1:0]   r2_re [NPP];
    logic signed [CORR_W-1:0]   r2_im [NPP];
    logic                       r_rd_ack, r_rd_err, r_rd_buf;
    logic [NPP*CORR_W-1:0]      r_re_corr;
    logic [NPP*CORR_W-1:0]      r_im_corr;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state and per-sample write/restart/completion decisions
    always_comb begin
        w_state_nxt = r_state;
        w_restart   = 1'b0;
        w_wr_en     = 1'b0;
        w_complete  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.sync && bus.din_vld) begin
                    w_state_nxt = ST_ACC;
                    w_restart   = 1'b1;
                    w_wr_en     = 1'b1;
                end
            end
            ST_ACC: begin
                if (bus.din_vld) begin
                    w_wr_en = 1'b1;
                    // a sync beats completion: the partial window is dropped, no swap
                    if (bus.sync)      w_restart  = 1'b1;
                    else if (&r_cnt)   w_complete = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Restart sample is antenna 0 of frame 0, written rather than added
    assign w_wr_ant = w_restart ? '0 : r_cnt[ANT_W-1:0];
    assign w_first  = w_restart || ((r_cnt >> ANT_W) == '0);
    assign w_wr_buf = ~r_buf_sel;

    // Valid-sample counter: low bits are the antenna, high bits the frame
    always_ff @(posedge clk) begin
        if (!rst_n)         r_cnt <= '0;
        else if (w_restart) r_cnt <= CNT_W'(1);
        else if (w_wr_en)   r_cnt <= r_cnt + CNT_W'(1);
    end

    // Buffer swap, completion pulse and first-window flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_buf_sel    <= 1'b0;
            r_first_done <= 1'b0;
            r_win_done   <= 1'b0;
        end else begin
            r_win_done <= w_complete;
            if (w_complete) begin
                r_buf_sel    <= ~r_buf_sel;
                r_first_done <= 1'b1;
            end
        end
    end

    // Lane sums per pol: unsigned real parts, signed imaginary parts, then S and D
    always_comb begin
        for (int p = 0; p < N_POLS; p++) begin
            w_re_sum[p] = '0;
            w_im_sum[p] = '0;
            for (int i = 0; i < P; i++) begin
                w_re_sum[p] = w_re_sum[p]
                    + ACC_IN_W'(bus.din_uint[(p*P+i)*BITWIDTH +: BITWIDTH]);
                w_im_sum[p] = w_im_sum[p]
                    + ACC_IN_W'($signed(bus.din_im[(p*P+i)*BITWIDTH +: BITWIDTH]));
            end
            w_s[p] = w_re_sum[p] + w_im_sum[p];
            w_d[p] = w_re_sum[p] - w_im_sum[p];
        end
    end

    // Accumulator memory; contents are never cleared, the first frame overwrites
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int p = 0; p < N_POLS; p++) begin
                if (w_first) begin
                    r_acc_s[w_wr_buf][w_wr_ant][p] <= ACC_W'(w_s[p]);
                    r_acc_d[w_wr_buf][w_wr_ant][p] <= ACC_W'(w_d[p]);
                end else begin
                    r_acc_s[w_wr_buf][w_wr_ant][p] <= r_acc_s[w_wr_buf][w_wr_ant][p] + ACC_W'(w_s[p]);
                    r_acc_d[w_wr_buf][w_wr_ant][p] <= r_acc_d[w_wr_buf][w_wr_ant][p] + ACC_W'(w_d[p]);
                end
            end
        end
    end

    // Read pipeline valid flags and held outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r1_vld    <= 1'b0;
            r2_vld    <= 1'b0;
            r_rd_ack  <= 1'b0;
            r_rd_err  <= 1'b0;
            r_rd_buf  <= 1'b0;
            r_re_corr <= '0;
            r_im_corr <= '0;
        end else begin
            r1_vld   <= bus.rd_req;
            r2_vld   <= r1_vld;
            r_rd_ack <= r2_vld;
            if (r2_vld) begin
                r_rd_err <= r2_err;
                r_rd_buf <= r2_buf;
                for (int k = 0; k < NPP; k++) begin
                    r_re_corr[k*CORR_W +: CORR_W] <= r2_err ? '0 : r2_re[k];
                    r_im_corr[k*CORR_W +: CORR_W] <= r2_err ? '0 : r2_im[k];
                end
            end
        end
    end

    // Read stage 1: buffer index and error flag are frozen at request time
    always_ff @(posedge clk) begin
        if (bus.rd_req) begin
            r1_err <= ~r_first_done;
            r1_buf <= r_buf_sel;
            for (int p = 0; p < N_POLS; p++) begin
                r1_sa[p] <= r_acc_s[r_buf_sel][bus.rd_ant_a][p];
                r1_da[p] <= r_acc_d[r_buf_sel][bus.rd_ant_a][p];
                r1_sb[p] <= r_acc_s[r_buf_sel][bus.rd_ant_b][p];
                r1_db[p] <= r_acc_d[r_buf_sel][bus.rd_ant_b][p];
            end
        end
    end

    // Read stage 2: all pol pairs, re = Sa+Sb and im = Db-Da
    always_ff @(posedge clk) begin
        if (r1_vld) begin
            r2_err <= r1_err;
            r2_buf <= r1_buf;
            for (int pa = 0; pa < N_POLS; pa++) begin
                for (int pb = 0; pb < N_POLS; pb++) begin
                    r2_re[pa*N_POLS+pb] <= CORR_W'(r1_sa[pa]) + CORR_W'(r1_sb[pb]);
                    r2_im[pa*N_POLS+pb] <= CORR_W'(r1_db[pb]) - CORR_W'(r1_da[pa]);
                end
            end
        end
    end

    assign bus.rd_ack   = r_rd_ack;
    assign bus.rd_err   = r_rd_err;
    assign bus.rd_buf   = r_rd_buf;
    assign bus.re_corr  = r_re_corr;
    assign bus.im_corr  = r_im_corr;
    assign bus.win_done = r_win_done;
    assign bus.buf_sel  = r_buf_sel;
endmodule
